// File: rtl/string_match_scheduler_if.sv
// Requester, processor and result signals of the string match scheduler.
// slave is the scheduler side, master is the environment side.
interface string_match_scheduler_if #(
   parameter int NUM_CHANNELS = 4
);
   localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic [8*NUM_CHANNELS-1:0] req_data;
   logic [NUM_CHANNELS-1:0]   req_valid;
   logic [NUM_CHANNELS-1:0]   req_last;
   logic [NUM_CHANNELS-1:0]   req_ready;
   logic [7:0]                proc_in_data;
   logic                      proc_in_valid;
   logic                      proc_in_last;
   logic [7:0]                proc_out_data;
   logic                      proc_out_valid;
   logic                      proc_out_last;
   logic [7:0]                out_data;
   logic                      out_valid;
   logic                      out_last;
   logic [CH_BITS-1:0]        out_channel;
   logic                      err_malformed;
   logic [CH_BITS-1:0]        err_channel;
   logic                      busy;

   modport slave (
      input  req_data, req_valid, req_last,
      input  proc_out_data, proc_out_valid, proc_out_last,
      output req_ready,
      output proc_in_data, proc_in_valid, proc_in_last,
      output out_data, out_valid, out_last, out_channel,
      output err_malformed, err_channel, busy
   );

   modport master (
      output req_data, req_valid, req_last,
      output proc_out_data, proc_out_valid, proc_out_last,
      input  req_ready,
      input  proc_in_data, proc_in_valid, proc_in_last,
      input  out_data, out_valid, out_last, out_channel,
      input  err_malformed, err_channel, busy
   );
endinterface

// File: rtl/string_match_scheduler.sv
// Round-robin sharing of one string match processor between byte streams.
// Whole jobs are granted; short jobs are padded so the processor stays aligned.
module string_match_scheduler #(
   parameter int NUM_CHANNELS = 4,
   parameter int STRING_SIZE  = 5,
   parameter int PROC_LATENCY = 1
) (
   input logic clock,
   input logic reset,
   string_match_scheduler_if.slave bus
);
   localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int CW      = $clog2(STRING_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE, NEEDLE, HAYSTACK, PAD, FLUSH
   } state_t;

   state_t                              state_q, state_d;
   logic [CH_BITS-1:0]                  rr_q, rr_d;
   logic [CH_BITS-1:0]                  grant_q, grant_d;
   logic [CW-1:0]                       cnt_q, cnt_d;
   logic                                err_q, err_d;
   logic [CH_BITS-1:0]                  err_ch_q, err_ch_d;
   logic [PROC_LATENCY-1:0]             drop_q;
   logic [PROC_LATENCY-1:0][CH_BITS-1:0] tch_q;

   logic               pick_found;
   logic [CH_BITS-1:0] pick_ch;
   int                 idx;
   logic               active, xfer, sel_last, push_drop;
   logic [7:0]         sel_data;
   logic [CW-1:0]      cnt_inc;
   logic [CH_BITS-1:0] next_rr;

   // First requesting channel at or after the round-robin pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      idx        = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!pick_found && bus.req_valid[idx]) begin
            pick_found = 1'b1;
            pick_ch    = CH_BITS'(idx);
         end
      end
   end

   assign active   = (state_q == NEEDLE) || (state_q == HAYSTACK);
   assign sel_data = bus.req_data[8*int'(grant_q) +: 8];
   assign sel_last = bus.req_last[grant_q];
   assign xfer     = active && bus.req_valid[grant_q];
   assign cnt_inc  = cnt_q + CW'(1);
   assign next_rr  = (grant_q == CH_BITS'(NUM_CHANNELS - 1)) ?
                     '0 : grant_q + CH_BITS'(1);

   // Only the granted channel is ready, and only while its job is open.
   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         bus.req_ready[i] = active && (grant_q == CH_BITS'(i));
   end

   // Job sequencing, processor drive and repair beat generation.
   always_comb begin
      state_d           = state_q;
      rr_d              = rr_q;
      grant_d           = grant_q;
      cnt_d             = cnt_q;
      err_d             = 1'b0;
      err_ch_d          = err_ch_q;
      push_drop         = 1'b1;
      bus.proc_in_valid = 1'b0;
      bus.proc_in_data  = 8'h00;
      bus.proc_in_last  = 1'b0;
      if (xfer) begin
         bus.proc_in_valid = 1'b1;
         bus.proc_in_data  = sel_data;
         bus.proc_in_last  = sel_last;
      end
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_ch;
               state_d = NEEDLE;
            end
         end
         NEEDLE: begin
            if (xfer) begin
               cnt_d            = cnt_inc;
               bus.proc_in_last = 1'b0;
               if (sel_last) begin
                  state_d = (cnt_inc == CW'(STRING_SIZE)) ? FLUSH : PAD;
               end else if (cnt_inc == CW'(STRING_SIZE)) begin
                  state_d = HAYSTACK;
                  cnt_d   = '0;
               end
            end
         end
         HAYSTACK: begin
            if (xfer) begin
               push_drop = 1'b0;
               if (sel_last) begin
                  state_d = IDLE;
                  rr_d    = next_rr;
                  cnt_d   = '0;
               end
            end
         end
         PAD: begin
            bus.proc_in_valid = 1'b1;
            cnt_d             = cnt_inc;
            if (cnt_inc == CW'(STRING_SIZE)) state_d = FLUSH;
         end
         FLUSH: begin
            bus.proc_in_valid = 1'b1;
            bus.proc_in_last  = 1'b1;
            err_d             = 1'b1;
            err_ch_d          = grant_q;
            state_d           = IDLE;
            rr_d              = next_rr;
            cnt_d             = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         grant_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         err_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         err_ch_q <= err_ch_d;
      end
   end

   // Tag line follows each processor beat through its latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_q <= '1;
         tch_q  <= '0;
      end else begin
         drop_q[0] <= push_drop;
         tch_q[0]  <= grant_q;
         for (int i = 1; i < PROC_LATENCY; i++) begin
            drop_q[i] <= drop_q[i-1];
            tch_q[i]  <= tch_q[i-1];
         end
      end
   end

   assign bus.out_data      = bus.proc_out_data;
   assign bus.out_valid     = bus.proc_out_valid & ~drop_q[PROC_LATENCY-1];
   assign bus.out_last      = bus.proc_out_last & ~drop_q[PROC_LATENCY-1];
   assign bus.out_channel   = tch_q[PROC_LATENCY-1];
   assign bus.err_malformed = err_q;
   assign bus.err_channel   = err_ch_q;
   assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_string_match_scheduler.sv
// Bench for string_match_scheduler: job-level model plus directed jobs.
// The processor is stood in for by a one-cycle echo of its input.
module tb_string_match_scheduler;
   localparam int N  = 4;
   localparam int SS = 5;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } in_t;
   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic [1:0] ch;
   } out_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   string_match_scheduler_if #(.NUM_CHANNELS(N)) bus ();

   string_match_scheduler #(
      .NUM_CHANNELS(N),
      .STRING_SIZE(SS),
      .PROC_LATENCY(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   // Processor stand-in: echoes every input beat one cycle later.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.proc_out_valid <= 1'b0;
         bus.proc_out_data  <= 8'h00;
         bus.proc_out_last  <= 1'b0;
      end else begin
         bus.proc_out_valid <= bus.proc_in_valid;
         bus.proc_out_data  <= bus.proc_in_data;
         bus.proc_out_last  <= bus.proc_in_last;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Requester byte buffers
   logic [7:0] bd [N][64];
   logic       bl [N][64];
   int hd[N], tl[N], gap_at[N], gap_len[N];
   logic [N-1:0] xf;

   // Model state
   in_t   exp_in[$];
   out_t  exp_out[$];
   int    exp_err[$];
   string pj [N][4];
   int    pn[N];
   int    m_rr = 0;

   // Phase observations
   int in_cnt, in_last_cnt, out_cnt, out_last_cnt, err_cnt;
   int ready1_cnt, stall_beats, gap_cyc, order, num_gaps, max_gap;
   int idle_run;
   bit seen_busy;
   logic [N-1:0] prev_ready;
   logic [63:0] out_w;
   in_t  ei;
   out_t eo;
   int   ee;

   task automatic job(input int c, input string s);
      for (int i = 0; i < s.len(); i++) begin
         bd[c][tl[c]] = s[i];
         bl[c][tl[c]] = (i == s.len() - 1);
         tl[c]++;
      end
      pj[c][pn[c]] = s;
      pn[c]++;
   endtask

   // Expected processor and result beats for one whole job.
   task automatic model_job(input int c, input string s);
      in_t  a;
      out_t b;
      int   n;
      n = s.len();
      for (int i = 0; i < n && i < SS; i++) begin
         a.d = s[i]; a.l = 1'b0; exp_in.push_back(a);
      end
      if (n <= SS) begin
         for (int i = n; i < SS; i++) begin
            a.d = 8'h00; a.l = 1'b0; exp_in.push_back(a);
         end
         a.d = 8'h00; a.l = 1'b1; exp_in.push_back(a);
         exp_err.push_back(c);
      end else begin
         for (int i = SS; i < n; i++) begin
            a.d = s[i]; a.l = (i == n - 1); exp_in.push_back(a);
            b.d = s[i]; b.l = (i == n - 1); b.ch = 2'(c);
            exp_out.push_back(b);
         end
      end
   endtask

   // Round-robin over jobs all pending at phase start.
   task automatic model_schedule();
      int pi[N];
      int c;
      bit any;
      for (int k = 0; k < N; k++) pi[k] = 0;
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         c = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (c < 0 && pi[j] < pn[j]) c = j;
         end
         if (c >= 0) begin
            any = 1'b1;
            model_job(c, pj[c][pi[c]]);
            pi[c]++;
            m_rr = (c + 1) % N;
         end
      end
      for (int k = 0; k < N; k++) pn[k] = 0;
   endtask

   // Requester drivers: hold valid until accepted, optional stall gap.
   initial begin
      logic [N-1:0]   v, l;
      logic [8*N-1:0] d;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      for (int c = 0; c < N; c++) begin
         hd[c] = 0; tl[c] = 0; gap_at[c] = -1; gap_len[c] = 0; pn[c] = 0;
      end
      forever begin
         @(negedge clock);
         xf = bus.req_valid & bus.req_ready;
         @(posedge clock);
         #1;
         v = '0; l = '0; d = '0;
         for (int c = 0; c < N; c++) begin
            if (xf[c]) hd[c]++;
            if (hd[c] < tl[c]) begin
               if (gap_len[c] > 0 && gap_at[c] == hd[c]) begin
                  gap_len[c]--;
               end else begin
                  v[c]         = 1'b1;
                  d[8*c +: 8]  = bd[c][hd[c]];
                  l[c]         = bl[c][hd[c]];
               end
            end
         end
         bus.req_valid = v;
         bus.req_data  = d;
         bus.req_last  = l;
      end
   end

   // Compare process: every beat checked against the model queues.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (bus.proc_in_valid) begin
               in_cnt++;
               if (bus.proc_in_last) in_last_cnt++;
               if (exp_in.size() == 0) begin
                  chk("proc_in_unexpected", 1, 0);
               end else begin
                  ei = exp_in.pop_front();
                  chk("proc_in_data", bus.proc_in_data, ei.d);
                  chk("proc_in_last", bus.proc_in_last, ei.l);
               end
            end
            if (bus.out_valid) begin
               out_cnt++;
               out_w = {out_w[55:0], bus.out_data};
               if (bus.out_last) out_last_cnt++;
               if (exp_out.size() == 0) begin
                  chk("out_unexpected", 1, 0);
               end else begin
                  eo = exp_out.pop_front();
                  chk("out_data", bus.out_data, eo.d);
                  chk("out_last", bus.out_last, eo.l);
                  chk("out_channel", bus.out_channel, eo.ch);
               end
            end
            if (bus.err_malformed) begin
               err_cnt++;
               if (exp_err.size() == 0) begin
                  chk("err_unexpected", 1, 0);
               end else begin
                  ee = exp_err.pop_front();
                  chk("err_channel", bus.err_channel, ee);
               end
            end
            if (bus.req_ready[1]) ready1_cnt++;
            if (bus.req_ready[3] && !bus.req_valid[3]) begin
               gap_cyc++;
               if (bus.proc_in_valid) stall_beats++;
            end
            if (bus.req_ready != '0 && prev_ready == '0) begin
               for (int c = 0; c < N; c++)
                  if (bus.req_ready[c]) order = order * 10 + c + 1;
            end
            prev_ready = bus.req_ready;
            if (bus.busy) begin
               if (seen_busy && idle_run > 0) begin
                  num_gaps++;
                  if (idle_run > max_gap) max_gap = idle_run;
               end
               seen_busy = 1'b1;
               idle_run  = 0;
            end else if (seen_busy) begin
               idle_run++;
            end
         end
      end
   end

   task automatic begin_phase();
      @(posedge clock);
      #1;
      in_cnt = 0; in_last_cnt = 0; out_cnt = 0; out_last_cnt = 0;
      err_cnt = 0; ready1_cnt = 0; stall_beats = 0; gap_cyc = 0;
      order = 0; num_gaps = 0; max_gap = 0; idle_run = 0;
      seen_busy = 1'b0; prev_ready = '0; out_w = '0;
      for (int c = 0; c < N; c++) begin
         hd[c] = 0; tl[c] = 0; gap_at[c] = -1; gap_len[c] = 0;
      end
   endtask

   task automatic run_phase(input string nm);
      bit done;
      int k;
      done = 1'b0;
      for (k = 0; k < 2000 && !done; k++) begin
         @(negedge clock);
         done = !bus.busy && exp_in.size() == 0 &&
                exp_out.size() == 0 && exp_err.size() == 0;
         for (int c = 0; c < N; c++) if (hd[c] != tl[c]) done = 1'b0;
      end
      chk({nm, "_completed"}, done, 1);
      repeat (3) @(negedge clock);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_proc_in_valid", bus.proc_in_valid, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_channel", bus.out_channel, 0);
      chk("rst_err", bus.err_malformed, 0);
      chk("rst_err_channel", bus.err_channel, 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Round robin over channels 0,2,3 with a second job on 0
      begin_phase();
      job(0, "hellox");
      job(2, "helloyz");
      job(3, "hellow");
      job(0, "hellov");
      model_schedule();
      run_phase("rr");
      chk("rr_order", order, 1341);
      chk("rr_gap_count", num_gaps, 3);
      chk("rr_gap_len", max_gap, 1);
      chk("rr_out_count", out_cnt, 5);

      // Well-formed job on channel 1
      begin_phase();
      job(1, "helloabc");
      model_schedule();
      run_phase("basic");
      chk("basic_out_bytes", out_w[23:0], 24'h616263);
      chk("basic_out_count", out_cnt, 3);
      chk("basic_out_last", out_last_cnt, 1);
      chk("basic_in_count", in_cnt, 8);
      chk("basic_in_last", in_last_cnt, 1);
      chk("basic_ready_cycles", ready1_cnt, 8);

      // Short needle on channel 2: pad then flush
      begin_phase();
      job(2, "ab");
      model_schedule();
      run_phase("short");
      chk("short_in_count", in_cnt, 6);
      chk("short_in_last", in_last_cnt, 1);
      chk("short_err_count", err_cnt, 1);
      chk("short_out_count", out_cnt, 0);
      chk("short_err_channel", bus.err_channel, 2);

      // Full needle, no haystack, on channel 0: flush only
      begin_phase();
      job(0, "hello");
      model_schedule();
      run_phase("nohay");
      chk("nohay_in_count", in_cnt, 6);
      chk("nohay_in_last", in_last_cnt, 1);
      chk("nohay_err_count", err_cnt, 1);
      chk("nohay_err_channel", bus.err_channel, 0);

      // Channel 3 stalls mid-haystack while channel 0 waits
      begin_phase();
      gap_at[3]  = 7;
      gap_len[3] = 4;
      job(3, "helloabcdef");
      job(0, "hellozz");
      model_schedule();
      run_phase("stall");
      chk("stall_order", order, 41);
      chk("stall_gap_cycles", gap_cyc, 4);
      chk("stall_beats", stall_beats, 0);
      chk("stall_out_count", out_cnt, 8);
      chk("stall_in_count", in_cnt, 18);

      // Reset mid-haystack, then a fresh job
      begin_phase();
      job(1, "helloabcdefghij");
      model_schedule();
      for (k = 0; k < 200 && out_cnt < 2; k++) @(negedge clock);
      chk("abort_reached_haystack", out_cnt >= 2, 1);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("abort_ready", bus.req_ready, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_proc_in_valid", bus.proc_in_valid, 0);
      exp_in.delete();
      exp_out.delete();
      exp_err.delete();
      for (int c = 0; c < N; c++) begin
         hd[c] = 0; tl[c] = 0;
      end
      m_rr = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      begin_phase();
      job(2, "hellopq");
      model_schedule();
      run_phase("fresh");
      chk("fresh_out_bytes", out_w[15:0], 16'h7071);
      chk("fresh_order", order, 3);
      chk("fresh_out_last", out_last_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/string_match_scheduler.md
Name: string_match_scheduler

Overview:
- Shares one string matching processor (byte stream: STRING_SIZE needle bytes, then haystack bytes terminated by last) between NUM_CHANNELS requester byte streams.
- Grants one whole job (needle plus haystack) at a time using round-robin arbitration.
- Tags the processor's output stream with the owning channel.
- Repairs malformed jobs (last asserted before the haystack begins) so the processor never desynchronises.

Parameters:
- NUM_CHANNELS, 4, number of requester streams (2..16)
- STRING_SIZE, 5, needle length in bytes; must equal the processor's STRING_SIZE
- PROC_LATENCY, 1, cycles from a processor input beat to its corresponding output beat (1..8)
- CH_BITS, $clog2(NUM_CHANNELS), channel index width (derived localparam)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_data  in  8*NUM_CHANNELS  channel i byte at [8i+7:8i]
- req_valid  in  NUM_CHANNELS  per-channel byte valid
- req_last  in  NUM_CHANNELS  per-channel end of job
- req_ready  out  NUM_CHANNELS  per-channel accept
- proc_in_data  out  8  to processor in_data
- proc_in_valid  out  1  to processor in_valid
- proc_in_last  out  1  to processor in_last
- proc_out_data  in  8  from processor out_data
- proc_out_valid  in  1  from processor out_valid
- proc_out_last  in  1  from processor out_last
- out_data  out  8  tagged result byte
- out_valid  out  1  result valid
- out_last  out  1  result end of job
- out_channel  out  CH_BITS  owning channel of the out beat
- err_malformed  out  1  one-cycle pulse: job was repaired
- err_channel  out  CH_BITS  channel of the last repaired job
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous) clears: state=IDLE, rr_ptr=0, grant=0, needle_cnt=0, tag line empty (all drop=1), err_malformed=0, err_channel=0. All outputs read 0 while reset is held. The processor shares the same reset.
- States: IDLE, NEEDLE, HAYSTACK, PAD, FLUSH.
- IDLE:
  - If any req_valid is set, grant the first asserted channel searching from rr_ptr upward with wrap-around; register it in grant; go to NEEDLE.
  - No data is accepted in IDLE, so there is one bubble cycle per job.
- req_ready[i] = (i == grant) && (state is NEEDLE or HAYSTACK). This is combinational from registers only. A beat transfers when valid && ready.
- proc_in_* is combinational: on a transfer it carries the granted channel's data and last; in PAD/FLUSH it carries the generated beats below; otherwise valid=0, data=0, last=0.
- NEEDLE, each transfer increments needle_cnt (width $clog2(STRING_SIZE+1)). On a transfer:
  - last=0 and cnt reaches STRING_SIZE: go to HAYSTACK, clear cnt.
  - last=1 and new cnt < STRING_SIZE: go to PAD. The beat is forwarded with proc_in_last forced to 0.
  - last=1 and new cnt == STRING_SIZE: go to FLUSH. The beat is forwarded with proc_in_last forced to 0.
- PAD:
  - Drive data=0x00, valid=1, last=0 every cycle, incrementing cnt.
  - When cnt reaches STRING_SIZE, go to FLUSH.
- FLUSH:
  - Drive a single beat data=0x00, valid=1, last=1.
  - Pulse err_malformed, set err_channel=grant, go to IDLE, rr_ptr=grant+1 (mod NUM_CHANNELS).
- HAYSTACK:
  - Forward transfers unchanged.
  - On a transfer with last=1: go to IDLE, rr_ptr=grant+1 (mod NUM_CHANNELS), clear cnt.
- Tag line:
  - A PROC_LATENCY-deep shift register of {channel, drop}, shifted every cycle.
  - Entry pushed: {grant, 0} for a haystack transfer; {grant, 1} for PAD/FLUSH beats or idle cycles.
- Result outputs:
  - out_data = proc_out_data.
  - out_valid = proc_out_valid & ~tail.drop.
  - out_last = proc_out_last & ~tail.drop.
  - out_channel = tail.channel.
  - Repair beats never reach the result stream.
- A requester deasserting valid mid-job stalls the job; the grant is held indefinitely (no timeout).
- A single requester gets back-to-back jobs separated by exactly one IDLE cycle.
- Reset asserted mid-job aborts the job immediately; the partial result stream is discarded.

Test Plan:
- Channel 1 sends "hello" then "abc" with last on 'c', valid held high → req_ready[1] high 8 cycles starting the cycle after the IDLE grant; proc_in sees h,e,l,l,o,a,b,c with last only on 'c'; out emits a,b,c with out_channel=1 and out_last on 'c'; busy drops after 'c'.
- Channels 0, 2, 3 all valid continuously, rr_ptr=0 → job order 0,2,3,0; exactly one IDLE cycle between jobs.
- Channel 2 sends "ab" with last on 'b' → proc_in sees a, b, three 0x00 pads, then 0x00 with last=1; err_malformed pulses once with err_channel=2; out_valid stays 0 throughout.
- Channel 0 sends "hello" with last on 'o' → proc_in sees exactly one FLUSH beat (0x00, last=1); err pulse; next grant proceeds normally.
- Channel 3 drops req_valid for 4 cycles mid-haystack → no proc_in beats during the gap; other requesters remain blocked; data order is preserved.
- Reset asserted mid-haystack → next clock edge sees state IDLE, all req_ready=0, out_valid=0; a fresh job then completes correctly.
